// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared RV32I definitions for the instruction encoder slice:
//   XLEN        - integer register / immediate width
//   fmt_e       - instruction encoding formats handled by the encoder
//   OPC_*       - base opcodes used when building programs
//   enc_state_e - load-session states of instr_encoder
// -----------------------------------------------------------------------------
package riscv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_J = 3'd4
    } fmt_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } enc_state_e;

endpackage

// File: rtl/instr_encoder_imm_pack.sv
// -----------------------------------------------------------------------------
// imm_pack
// Purely combinational placement of a sign-extended immediate into the
// instruction bit positions its format uses. All non-immediate positions are
// zero so the caller can OR in opcode/register/funct fields.
// Ports:
//   fmt      in   instruction format
//   imm      in   sign-extended immediate (byte offset for B/J)
//   imm_bits out  32-bit word holding only the immediate fields
//   imm_ok   out  immediate representable in the format (always 1 unless
//                 INSTR_ENCODER_RANGE_CHECK_EN is defined)
// Optional feature macro: INSTR_ENCODER_RANGE_CHECK_EN
// -----------------------------------------------------------------------------
module imm_pack #(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  riscv_pkg::fmt_e    fmt,
    input  logic [XLEN-1:0]    imm,
    output logic [31:0]        imm_bits,
    output logic               imm_ok
);
    import riscv_pkg::*;

    always_comb begin
        imm_bits = '0;
        case (fmt)
            FMT_I: imm_bits[31:20] = imm[11:0];
            FMT_S: begin
                imm_bits[31:25] = imm[11:5];
                imm_bits[11:7]  = imm[4:0];
            end
            FMT_B: begin
                imm_bits[31]    = imm[12];
                imm_bits[30:25] = imm[10:5];
                imm_bits[11:8]  = imm[4:1];
                imm_bits[7]     = imm[11];
            end
            FMT_J: imm_bits[31:12] = {imm[20], imm[10:1], imm[11], imm[19:12]};
            default: ;
        endcase
    end

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
    // agree[i]: bit i equals the sign bit. A value fits an N-bit signed field
    // when every bit from N-1 upward agrees with the sign.
    logic [XLEN-1:11] agree;
    logic             fit12;
    logic             fit13;
    logic             fit21;

    for (genvar gi = 11; gi < XLEN; gi++) begin : g_agree
        assign agree[gi] = (imm[gi] == imm[XLEN-1]);
    end

    assign fit12 = &agree[XLEN-1:11];
    assign fit13 = &agree[XLEN-1:12];
    assign fit21 = &agree[XLEN-1:20];

    always_comb begin
        imm_ok = 1'b1;
        case (fmt)
            FMT_I, FMT_S: imm_ok = fit12;
            FMT_B:        imm_ok = fit13 && !imm[0];
            FMT_J:        imm_ok = fit21 && !imm[0];
            default:      imm_ok = 1'b1;
        endcase
    end
`else
    // Without checking, bits above the widest field are simply dropped.
    logic unused_imm_high;
    assign unused_imm_high = &{1'b0, imm[XLEN-1:21]};
    assign imm_ok = 1'b1;
`endif

endmodule

// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
// Streaming RV32I encoder: packs decoded field bundles into 32-bit words and
// presents them, with word-aligned byte addresses, to an instruction-memory
// write port through a single-entry output register.
// Parameters:
//   XLEN       immediate input width
//   BASE_ADDR  first write address of a session (4-byte aligned)
//   MAX_WORDS  bundles accepted per session before the session is forced to end
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   start                 begin a session (honoured in IDLE / DONE only)
//   in_valid/in_ready     field-bundle handshake
//   in_fmt .. in_last     decoded fields, in_last closes the session
//   out_valid/out_ready   encoded-word handshake
//   out_addr, out_instr   byte address and encoded word
//   busy, done, err       LOAD|DRAIN, DONE, sticky range error
//   word_count            words emitted this session
// Optional feature macro: INSTR_ENCODER_RANGE_CHECK_EN (immediate range check)
// -----------------------------------------------------------------------------
module instr_encoder #(
    parameter int          XLEN      = riscv_pkg::XLEN,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 1024
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  riscv_pkg::fmt_e                  in_fmt,
    input  logic [6:0]                       in_opcode,
    input  logic [2:0]                       in_funct3,
    input  logic [6:0]                       in_funct7,
    input  logic [4:0]                       in_rd,
    input  logic [4:0]                       in_rs1,
    input  logic [4:0]                       in_rs2,
    input  logic [XLEN-1:0]                  in_imm,
    input  logic                             in_last,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [31:0]                      out_addr,
    output logic [31:0]                      out_instr,
    output logic                             busy,
    output logic                             done,
    output logic                             err,
    output logic [$clog2(MAX_WORDS+1)-1:0]   word_count
);
    import riscv_pkg::*;

    localparam int CNT_W = $clog2(MAX_WORDS + 1);

    enc_state_e        state_reg, state_next;
    logic              out_valid_reg;
    logic [31:0]       out_addr_reg;
    logic [31:0]       out_instr_reg;
    logic [31:0]       addr_cnt_reg;
    logic [CNT_W-1:0]  word_count_reg;
    logic [CNT_W-1:0]  accept_cnt_reg;

    logic [31:0]       imm_bits;
    logic [31:0]       instr_next;
    logic              imm_ok;
    logic              accept;
    logic              emit;
    logic              start_ok;
    logic              session_end;

    imm_pack #(.XLEN(XLEN)) u_imm_pack (
        .fmt      (in_fmt),
        .imm      (in_imm),
        .imm_bits (imm_bits),
        .imm_ok   (imm_ok)
    );

    // The output register can take a new word when empty or when its current
    // word leaves this very cycle, so back-to-back words need no bubble.
    assign in_ready    = (state_reg == ST_LOAD) && (!out_valid_reg || out_ready);
    assign accept      = in_valid && in_ready;
    assign emit        = accept && imm_ok;
    assign start_ok    = start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
    // The session closes on in_last or on the MAX_WORDS-th accepted bundle,
    // counting rejected bundles too since they were consumed.
    assign session_end = accept && (in_last || (accept_cnt_reg == CNT_W'(MAX_WORDS - 1)));

    always_comb begin
        instr_next = {25'b0, in_opcode};
        case (in_fmt)
            FMT_R:        instr_next = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
            FMT_I:        instr_next = imm_bits | {12'b0, in_rs1, in_funct3, in_rd, in_opcode};
            FMT_S, FMT_B: instr_next = imm_bits | {7'b0, in_rs2, in_rs1, in_funct3, 5'b0, in_opcode};
            FMT_J:        instr_next = imm_bits | {20'b0, in_rd, in_opcode};
            default:      instr_next = {25'b0, in_opcode};
        endcase
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (start) state_next = ST_LOAD;
            ST_LOAD:  if (session_end) state_next = ST_DRAIN;
            // Leave DRAIN on the edge that empties the register, so done
            // rises the cycle right after the last output handshake.
            ST_DRAIN: if (!out_valid_reg || out_ready) state_next = ST_DONE;
            ST_DONE:  if (start) state_next = ST_LOAD;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            out_valid_reg  <= 1'b0;
            out_addr_reg   <= '0;
            out_instr_reg  <= '0;
            addr_cnt_reg   <= BASE_ADDR;
            word_count_reg <= '0;
            accept_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;

            if (emit) begin
                out_valid_reg  <= 1'b1;
                out_addr_reg   <= addr_cnt_reg;
                out_instr_reg  <= instr_next;
                addr_cnt_reg   <= addr_cnt_reg + 32'd4;
                word_count_reg <= word_count_reg + 1'b1;
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
            end

            if (accept) begin
                accept_cnt_reg <= accept_cnt_reg + 1'b1;
            end

            // start is only honoured outside LOAD/DRAIN, so it never
            // collides with an emitted word above.
            if (start_ok) begin
                addr_cnt_reg   <= BASE_ADDR;
                word_count_reg <= '0;
                accept_cnt_reg <= '0;
            end
        end
    end

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
    logic err_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_reg <= 1'b0;
        end else if (start_ok) begin
            err_reg <= 1'b0;
        end else if (accept && !imm_ok) begin
            err_reg <= 1'b1;
        end
    end

    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

    assign out_valid  = out_valid_reg;
    assign out_addr   = out_addr_reg;
    assign out_instr  = out_instr_reg;
    assign busy       = (state_reg == ST_LOAD) || (state_reg == ST_DRAIN);
    assign done       = (state_reg == ST_DONE);
    assign word_count = word_count_reg;

endmodule

// File: tb/tb_instr_encoder.sv
// -----------------------------------------------------------------------------
// tb_instr_encoder
// Scoreboard bench for instr_encoder: each accepted bundle pushes its expected
// address/word (and immediate, for decode round-trip) into a queue, and the
// monitor pops and compares on every output handshake.
// Honours INSTR_ENCODER_RANGE_CHECK_EN in the same way as the design.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_instr_encoder;
    import riscv_pkg::*;

    localparam logic [31:0] BASE = 32'h0000_0100;
    localparam int          MAXW = 8;
    localparam int          CW   = $clog2(MAXW + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    fmt_e          in_fmt = FMT_R;
    logic [6:0]    in_opcode = '0;
    logic [2:0]    in_funct3 = '0;
    logic [6:0]    in_funct7 = '0;
    logic [4:0]    in_rd = '0;
    logic [4:0]    in_rs1 = '0;
    logic [4:0]    in_rs2 = '0;
    logic [31:0]   in_imm = '0;
    logic          in_last = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [31:0]   out_addr;
    logic [31:0]   out_instr;
    logic          busy;
    logic          done;
    logic          err;
    logic [CW-1:0] word_count;

    instr_encoder #(.XLEN(32), .BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt),
        .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_instr(out_instr), .busy(busy), .done(done),
        .err(err), .word_count(word_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] imm;
        fmt_e        fmt;
        bit          chk_dec;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_pops   = 0;
    logic [31:0] exp_addr;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] enc(input fmt_e f, input logic [6:0] op, input logic [2:0] f3,
                                        input logic [6:0] f7, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic [31:0] im);
        case (f)
            FMT_R:   return {f7, rs2, rs1, f3, rd, op};
            FMT_I:   return {im[11:0], rs1, f3, rd, op};
            FMT_S:   return {im[11:5], rs2, rs1, f3, im[4:0], op};
            FMT_B:   return {im[12], im[10:5], rs2, rs1, f3, im[4:1], im[11], op};
            FMT_J:   return {im[20], im[10:1], im[11], im[19:12], rd, op};
            default: return 32'h0;
        endcase
    endfunction

    // Reference immediate decoder, used for the round-trip check.
    function automatic logic [31:0] dec_imm(input fmt_e f, input logic [31:0] i);
        case (f)
            FMT_I:   return {{20{i[31]}}, i[31:20]};
            FMT_S:   return {{20{i[31]}}, i[31:25], i[11:7]};
            FMT_B:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            FMT_J:   return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: return 32'h0;
        endcase
    endfunction

    // Present one bundle and hold it until accepted; the expected word is
    // queued at the negedge preceding the accepting edge.
    task automatic send(input fmt_e f, input logic [6:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] im, input logic last,
                        input logic [31:0] exp_instr, input bit emit_exp, input bit chk);
        exp_t e;
        int   t;
        in_fmt = f; in_opcode = op; in_funct3 = f3; in_funct7 = f7;
        in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = im; in_last = last;
        in_valid = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!in_ready && t < 40);
        if (!in_ready) begin
            check_eq("in_ready_timeout", {31'b0, in_ready}, 32'd1);
        end else if (emit_exp) begin
            e.addr = exp_addr; e.instr = exp_instr; e.imm = im; e.fmt = f; e.chk_dec = chk;
            sb.push_back(e);
            exp_addr += 32'd4;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        exp_addr = BASE;
    endtask

    task automatic wait_pops(input int target);
        int t;
        t = 0;
        while (n_pops < target && t < 200) begin
            @(posedge clk);
            t++;
        end
        if (n_pops < target) check_eq("drain_timeout", n_pops, target);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_out_valid"},  {31'b0, out_valid}, 32'd0);
        check_eq({tag, "_out_addr"},   out_addr, 32'd0);
        check_eq({tag, "_out_instr"},  out_instr, 32'd0);
        check_eq({tag, "_in_ready"},   {31'b0, in_ready}, 32'd0);
        check_eq({tag, "_busy"},       {31'b0, busy}, 32'd0);
        check_eq({tag, "_done"},       {31'b0, done}, 32'd0);
        check_eq({tag, "_err"},        {31'b0, err}, 32'd0);
        check_eq({tag, "_word_count"}, 32'(word_count), 32'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check_eq("sb_nonempty", sb.size(), 32'd1);
            end else begin
                mon_e = sb.pop_front();
                $display("word addr=%h instr=%h exp_addr=%h exp_instr=%h",
                         out_addr, out_instr, mon_e.addr, mon_e.instr);
                check_eq("out_addr", out_addr, mon_e.addr);
                check_eq("out_instr", out_instr, mon_e.instr);
                if (mon_e.chk_dec) check_eq("imm_roundtrip", dec_imm(mon_e.fmt, out_instr), mon_e.imm);
                n_pops++;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        fmt_e        fl [5];
        logic [6:0]  ol [5];
        logic [31:0] r, im;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        int          p0;

        fl = '{FMT_I, FMT_S, FMT_B, FMT_J, FMT_R};
        ol = '{OPC_OP_IMM, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_OP};
        exp_addr = BASE;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Fixed encodings and first-word latency.
        do_start();
        @(negedge clk);
        check_eq("busy_after_start", {31'b0, busy}, 32'd1);
        @(posedge clk); #1;
        p0 = n_pops;
        send(FMT_I, OPC_OP_IMM, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 32'h00500093, 1, 1);
        check_eq("latency_valid", {31'b0, out_valid}, 32'd1);
        check_eq("latency_instr", out_instr, 32'h00500093);
        check_eq("latency_addr", out_addr, BASE);
        send(FMT_S, OPC_STORE, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, -32'sd4, 1'b0, 32'hFE20AE23, 1, 1);
        send(FMT_B, OPC_BRANCH, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, -32'sd8, 1'b0, 32'hFE000CE3, 1, 1);
        send(FMT_J, OPC_JAL, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b1, 32'h001000EF, 1, 1);
        wait_pops(p0 + 4);
        @(negedge clk);
        check_eq("fixed_done", {31'b0, done}, 32'd1);
        check_eq("fixed_word_count", 32'(word_count), 32'd4);
        @(posedge clk); #1;

        // 4-word burst with out_ready held low for 3 cycles.
        do_start();
        p0 = n_pops;
        fork
            begin
                for (int k = 0; k < 4; k++) begin
                    im = 32'(k * 16);
                    send(FMT_I, OPC_OP_IMM, 3'd0, 7'd0, 5'(k + 1), 5'd2, 5'd0, im, (k == 3),
                         enc(FMT_I, OPC_OP_IMM, 3'd0, 7'd0, 5'(k + 1), 5'd2, 5'd0, im), 1, 1);
                end
            end
            begin
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_pops(p0 + 4);
        @(negedge clk);
        check_eq("burst_done", {31'b0, done}, 32'd1);
        check_eq("burst_busy", {31'b0, busy}, 32'd0);
        check_eq("burst_word_count", 32'(word_count), 32'd4);
        check_eq("burst_next_addr", exp_addr, BASE + 32'd16);
        @(posedge clk); #1;

        // Random round-trip, one session per format; a start pulse mid-session
        // must be ignored.
        for (int fi = 0; fi < 5; fi++) begin
            do_start();
            p0 = n_pops;
            for (int k = 0; k < 6; k++) begin
                r = $urandom;
                case (fl[fi])
                    FMT_I, FMT_S: im = {{20{r[11]}}, r[11:0]};
                    FMT_B:        im = {{19{r[12]}}, r[12:1], 1'b0};
                    FMT_J:        im = {{11{r[20]}}, r[20:1], 1'b0};
                    default:      im = r;
                endcase
                rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
                f3 = 3'($urandom); f7 = 7'($urandom);
                send(fl[fi], ol[fi], f3, f7, rd, rs1, rs2, im, (k == 5),
                     enc(fl[fi], ol[fi], f3, f7, rd, rs1, rs2, im), 1, (fl[fi] != FMT_R));
                if (k == 2) do_start_ignored();
            end
            wait_pops(p0 + 6);
            @(negedge clk);
            check_eq("rand_done", {31'b0, done}, 32'd1);
            check_eq("rand_word_count", 32'(word_count), 32'd6);
            @(posedge clk); #1;
        end

        // MAX_WORDS bundles without in_last force the session to end.
        do_start();
        p0 = n_pops;
        for (int k = 0; k < MAXW; k++) begin
            send(FMT_R, OPC_OP, 3'd0, 7'd0, 5'(k), 5'd3, 5'd4, 32'd0, 1'b0,
                 enc(FMT_R, OPC_OP, 3'd0, 7'd0, 5'(k), 5'd3, 5'd4, 32'd0), 1, 0);
        end
        @(negedge clk);
        check_eq("max_in_ready_low", {31'b0, in_ready}, 32'd0);
        wait_pops(p0 + MAXW);
        @(negedge clk);
        check_eq("max_done", {31'b0, done}, 32'd1);
        check_eq("max_word_count", 32'(word_count), 32'(MAXW));
        @(posedge clk); #1;

        // Out-of-range immediates.
        do_start();
        p0 = n_pops;
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
        send(FMT_I, OPC_OP_IMM, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0, 32'h0, 0, 0);
        send(FMT_B, OPC_BRANCH, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3, 1'b0, 32'h0, 0, 0);
        @(negedge clk);
        check_eq("range_err", {31'b0, err}, 32'd1);
        check_eq("range_no_word", {31'b0, out_valid}, 32'd0);
        @(posedge clk); #1;
        send(FMT_I, OPC_OP_IMM, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 32'h00500093, 1, 1);
        wait_pops(p0 + 1);
        @(negedge clk);
        check_eq("range_word_count", 32'(word_count), 32'd1);
`else
        send(FMT_I, OPC_OP_IMM, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0,
             enc(FMT_I, OPC_OP_IMM, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048), 1, 0);
        send(FMT_B, OPC_BRANCH, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3, 1'b1,
             enc(FMT_B, OPC_BRANCH, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3), 1, 0);
        wait_pops(p0 + 2);
        @(negedge clk);
        check_eq("norange_err", {31'b0, err}, 32'd0);
        check_eq("norange_word_count", 32'(word_count), 32'd2);
`endif
        check_eq("range_done", {31'b0, done}, 32'd1);
        @(posedge clk); #1;
        do_start();
        @(negedge clk);
        check_eq("err_cleared", {31'b0, err}, 32'd0);
        @(posedge clk); #1;

        // Reset during LOAD with a word pending.
        out_ready = 1'b0;
        send(FMT_I, OPC_OP_IMM, 3'd0, 7'd0, 5'd7, 5'd0, 5'd0, 32'd1, 1'b0,
             enc(FMT_I, OPC_OP_IMM, 3'd0, 7'd0, 5'd7, 5'd0, 5'd0, 32'd1), 1, 1);
        check_eq("pending_valid", {31'b0, out_valid}, 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("midreset");
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        do_start();
        p0 = n_pops;
        send(FMT_I, OPC_OP_IMM, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 32'h00500093, 1, 1);
        wait_pops(p0 + 1);
        @(negedge clk);
        check_eq("restart_done", {31'b0, done}, 32'd1);
        check_eq("restart_word_count", 32'(word_count), 32'd1);
        check_eq("sb_drained", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // A start pulse during LOAD, which must not disturb the session.
    task automatic do_start_ignored();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Streaming RV32I instruction encoder, the write-side counterpart of the immediate decoder: accepts decoded instruction fields (format, opcode, funct, registers, sign-extended immediate) and packs them into 32-bit instruction words. Emits each word with a word-aligned address to the instruction-memory write port. Used by the boot/debug program loader and by self-checking benches to build programs in-system.

## Interface
- XLEN, riscv_pkg::XLEN: immediate input width.
- BASE_ADDR, 32'h0000_0000: first write address after `start`; must be 4-byte aligned.
- MAX_WORDS, 1024: words accepted per load session before forced DONE.
- clk  in  1  clock; all logic on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a load session; ignored unless state is IDLE or DONE.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  encoder accepts the bundle this cycle.
- in_fmt  in  riscv_pkg::fmt_e  FMT_R, FMT_I, FMT_S, FMT_B, FMT_J.
- in_opcode  in  7  opcode[6:0].
- in_funct3  in  3  funct3; ignored for FMT_J.
- in_funct7  in  7  funct7; used only for FMT_R.
- in_rd / in_rs1 / in_rs2  in  5 each  register indices; unused ones ignored per format.
- in_imm  in  XLEN  sign-extended immediate, byte offset for B/J.
- in_last  in  1  marks the final bundle of the session.
- out_valid  out  1  encoded word valid.
- out_ready  in  1  memory port accepts the word.
- out_addr  out  32  byte address of the word.
- out_instr  out  32  encoded instruction.
- busy  out  1  state is LOAD or DRAIN.
- done  out  1  state is DONE.
- err  out  1  sticky range-error flag; cleared by `start`.
- word_count  out  $clog2(MAX_WORDS+1)  words emitted this session.

## Operation
- FSM states: IDLE, LOAD, DRAIN, DONE.
  - IDLE -> LOAD on `start`.
  - LOAD -> DRAIN on an accepted bundle with `in_last`, or on the MAX_WORDS-th accepted bundle.
  - DRAIN -> DONE when the output register is empty.
  - DONE -> LOAD on `start`.
- `start` in LOAD or DRAIN is ignored.
- `in_ready` is high only in LOAD, and only when `!out_valid || out_ready` (single-entry pipeline register with pass-through of back-pressure).
- Bit packing per format, inverse of the decoder:
  - R: {funct7, rs2, rs1, funct3, rd, opcode}.
  - I: {imm[11:0], rs1, funct3, rd, opcode}.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
- Address counter:
  - Loaded with BASE_ADDR on `start`.
  - `out_addr` takes the current counter on accept.
  - Counter += 4 on each emitted (non-rejected) word; wraps modulo 2^32.
- `word_count` increments once per emitted word; cleared to 0 on `start`.
- Simultaneous `out_ready` handshake and new accept in the same cycle: the register is replaced; no bubble.
- Reset values: state IDLE, `out_valid` 0, `out_addr` 0, `out_instr` 0, `in_ready` 0, `busy` 0, `done` 0, `err` 0, `word_count` 0, counter BASE_ADDR.
- `rst_n` low mid-session: the pending word is discarded, with no further `out_valid`.

## Timing
- Latency: bundle accepted in cycle N -> `out_valid` with its word in N+1.
- Throughput: one word per cycle while `out_ready` stays high.
- `out_addr` and `out_instr` stay stable while `out_valid && !out_ready`.
- `done` asserts the cycle after the last word's output handshake.

## Configuration
- INSTR_ENCODER_RANGE_CHECK_EN defined:
  - An accepted bundle whose immediate does not fit is consumed but not emitted. Limits: I/S signed 12-bit; B signed 13-bit and even; J signed 21-bit and even.
  - Rejection sets `err`, does not advance the address, and does not increment `word_count`.
  - `in_last` on a rejected bundle still moves LOAD -> DRAIN.
- Undefined: no checking; immediate bits outside the field are dropped silently (B/J bit 0 ignored). `err` is tied to 0.

## Structure
- riscv_pkg gains `fmt_e` and opcode constants OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL.
- Sub-module `imm_pack`: purely combinational. Inputs: fmt, imm. Outputs: the instruction bits occupied by the immediate, plus `imm_ok` for the range check.
- FSM, address counter and output register live in `instr_encoder`.

## Test plan
- Encode `addi x1,x0,5` (FMT_I, imm 5) -> out_instr 32'h00500093 at out_addr BASE_ADDR, one cycle after accept.
- Encode `sw x2,-4(x1)` (FMT_S) -> 32'hFE20AE23; encode `beq x0,x0,-8` (FMT_B) -> 32'hFE000CE3.
- Encode `jal x1,2048` (FMT_J) -> 32'h001000EF; round-trip every format through the immediate decoder with random immediates -> decoded value equals input.
- Hold `out_ready` low for 3 cycles during a 4-word burst -> no word lost or duplicated, addresses BASE_ADDR..BASE_ADDR+12, `word_count` 4, `done` asserted after the final handshake.
- With RANGE_CHECK_EN: FMT_I imm 2048, then B imm 3 -> neither emitted, `err`=1, next valid word still at BASE_ADDR.
- Pull `rst_n` low during LOAD with `out_valid`=1 -> next cycle all outputs at reset values; `start` afterwards restarts at BASE_ADDR.
